// File: rtl/tm_qm_ctrl.sv
// tm_qm_ctrl -- queue-manager control engine for the second-level TM queues.
// Serialises enqueue/dequeue requests into read-modify-write sequences on
// the head, tail, depth, depth1, linked-list and packet-descriptor RAMs.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   enq_valid/ready/qid/ptr/desc   enqueue request handshake and payload
//   enq_done, enq_drop             enqueue completion (drop = queue saturated)
//   deq_valid/ready/qid            dequeue request handshake
//   deq_done, deq_empty            dequeue completion (empty = nothing returned)
//   deq_ptr, deq_desc              dequeued buffer pointer and descriptor
//   {head,tail,depth,depth1}_*     per-queue RAM controls (addressed by qid)
//   ll_*, pkt_desc_*               per-buffer RAM controls (addressed by ptr)

package tm_qm_pkg;
   localparam int SECOND_LVL_QUEUE_ID_NBITS = 8;

   typedef struct packed {
      logic [15:0] pkt_len;
      logic [7:0]  src_port;
   } sch_pkt_desc_type;
endpackage

module tm_qm_ctrl
   import tm_qm_pkg::*;
#(
   parameter int QUEUE_ID_NBITS      = SECOND_LVL_QUEUE_ID_NBITS,
   parameter int QUEUE_ENTRIES_NBITS = SECOND_LVL_QUEUE_ID_NBITS
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           enq_valid,
   output logic                           enq_ready,
   input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] enq_ptr,
   input  sch_pkt_desc_type               enq_desc,
   output logic                           enq_done,
   output logic                           enq_drop,
   input  logic                           deq_valid,
   output logic                           deq_ready,
   input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
   output logic                           deq_done,
   output logic                           deq_empty,
   output logic [QUEUE_ENTRIES_NBITS-1:0] deq_ptr,
   output sch_pkt_desc_type               deq_desc,
   output logic                           head_wr,
   output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
   output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
   output logic                           tail_wr,
   output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
   output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,
   output logic                           depth_wr,
   output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
   output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,
   output logic                           depth1_wr,
   output logic [QUEUE_ID_NBITS-1:0]      depth1_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] depth1_wdata,
   output logic [QUEUE_ID_NBITS-1:0]      depth1_raddr,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] depth1_rdata,
   output logic                           ll_wr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
   output logic                           pkt_desc_wr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_waddr,
   output sch_pkt_desc_type               pkt_desc_wdata,
   output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_raddr,
   input  sch_pkt_desc_type               pkt_desc_rdata
);

   localparam logic [QUEUE_ENTRIES_NBITS-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, ENQ_RD, DEQ_RD, DEQ_LL} state_t;

   state_t                           state, state_nxt;
   logic                             last_deq;
   logic [QUEUE_ID_NBITS-1:0]        qid_q;
   logic [QUEUE_ENTRIES_NBITS-1:0]   ptr_q;
   sch_pkt_desc_type                 desc_q;
   logic [QUEUE_ENTRIES_NBITS-1:0]   head_q;
   logic [QUEUE_ENTRIES_NBITS-1:0]   depth_q;
   logic                             enq_drop_q;
   logic                             deq_empty_q;
   logic [QUEUE_ENTRIES_NBITS-1:0]   deq_ptr_q;
   sch_pkt_desc_type                 deq_desc_q;
   logic                             grant_enq, grant_deq;

   // depth1 is the scheduler's read copy; this engine only ever writes it.
   logic unused_depth1;
   assign unused_depth1 = ^depth1_rdata;

   // Next-state and output decode. Handshakes are gated by rstn so every
   // output reads 0 while reset is held. Status outputs replay their held
   // register except in the cycle that produces a new value.
   always_comb begin
      state_nxt      = state;
      enq_ready      = 1'b0;
      deq_ready      = 1'b0;
      enq_done       = 1'b0;
      deq_done       = 1'b0;
      enq_drop       = enq_drop_q;
      deq_empty      = deq_empty_q;
      deq_ptr        = deq_ptr_q;
      deq_desc       = deq_desc_q;
      head_wr        = 1'b0;
      head_waddr     = '0;
      head_wdata     = '0;
      head_raddr     = '0;
      tail_wr        = 1'b0;
      tail_waddr     = '0;
      tail_wdata     = '0;
      tail_raddr     = '0;
      depth_wr       = 1'b0;
      depth_waddr    = '0;
      depth_wdata    = '0;
      depth_raddr    = '0;
      depth1_wr      = 1'b0;
      depth1_waddr   = '0;
      depth1_wdata   = '0;
      depth1_raddr   = '0;
      ll_wr          = 1'b0;
      ll_waddr       = '0;
      ll_wdata       = '0;
      ll_raddr       = '0;
      pkt_desc_wr    = 1'b0;
      pkt_desc_waddr = '0;
      pkt_desc_wdata = '0;
      pkt_desc_raddr = '0;
      // Under contention the op that did not win last time is granted.
      grant_enq      = rstn && enq_valid && (!deq_valid || last_deq);
      grant_deq      = rstn && deq_valid && (!enq_valid || !last_deq);

      case (state)
         IDLE: begin
            if (grant_enq) begin
               enq_ready   = 1'b1;
               tail_raddr  = enq_qid;
               depth_raddr = enq_qid;
               state_nxt   = ENQ_RD;
            end else if (grant_deq) begin
               deq_ready   = 1'b1;
               head_raddr  = deq_qid;
               depth_raddr = deq_qid;
               state_nxt   = DEQ_RD;
            end
         end
         ENQ_RD: begin
            enq_done  = 1'b1;
            state_nxt = IDLE;
            if (depth_rdata == '1) begin
               enq_drop = 1'b1;
            end else begin
               enq_drop = 1'b0;
               // Empty queue starts at this buffer; otherwise link it behind the tail.
               if (depth_rdata == '0) begin
                  head_wr    = 1'b1;
                  head_waddr = qid_q;
                  head_wdata = ptr_q;
               end else begin
                  ll_wr    = 1'b1;
                  ll_waddr = tail_rdata;
                  ll_wdata = ptr_q;
               end
               tail_wr        = 1'b1;
               tail_waddr     = qid_q;
               tail_wdata     = ptr_q;
               depth_wr       = 1'b1;
               depth_waddr    = qid_q;
               depth_wdata    = depth_rdata + ONE;
               depth1_wr      = 1'b1;
               depth1_waddr   = qid_q;
               depth1_wdata   = depth_rdata + ONE;
               pkt_desc_wr    = 1'b1;
               pkt_desc_waddr = ptr_q;
               pkt_desc_wdata = desc_q;
            end
         end
         DEQ_RD: begin
            if (depth_rdata == '0) begin
               deq_done  = 1'b1;
               deq_empty = 1'b1;
               state_nxt = IDLE;
            end else begin
               ll_raddr       = head_rdata;
               pkt_desc_raddr = head_rdata;
               state_nxt      = DEQ_LL;
            end
         end
         DEQ_LL: begin
            deq_done     = 1'b1;
            deq_empty    = 1'b0;
            deq_ptr      = head_q;
            deq_desc     = pkt_desc_rdata;
            depth_wr     = 1'b1;
            depth_waddr  = qid_q;
            depth_wdata  = depth_q - ONE;
            depth1_wr    = 1'b1;
            depth1_waddr = qid_q;
            depth1_wdata = depth_q - ONE;
            // Last entry leaves head/tail stale; a zero depth marks them invalid.
            if (depth_q > ONE) begin
               head_wr    = 1'b1;
               head_waddr = qid_q;
               head_wdata = ll_rdata;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, request latches and held completion status.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         last_deq    <= 1'b1;
         qid_q       <= '0;
         ptr_q       <= '0;
         desc_q      <= '0;
         head_q      <= '0;
         depth_q     <= '0;
         enq_drop_q  <= 1'b0;
         deq_empty_q <= 1'b0;
         deq_ptr_q   <= '0;
         deq_desc_q  <= '0;
      end else begin
         state <= state_nxt;
         if (enq_ready) begin
            qid_q    <= enq_qid;
            ptr_q    <= enq_ptr;
            desc_q   <= enq_desc;
            last_deq <= 1'b0;
         end else if (deq_ready) begin
            qid_q    <= deq_qid;
            last_deq <= 1'b1;
         end
         if (state == DEQ_RD) begin
            head_q  <= head_rdata;
            depth_q <= depth_rdata;
         end
         if (enq_done) begin
            enq_drop_q <= enq_drop;
         end
         if (deq_done) begin
            deq_empty_q <= deq_empty;
            deq_ptr_q   <= deq_ptr;
            deq_desc_q  <= deq_desc;
         end
      end
   end

endmodule

// File: tb/tb_tm_qm_ctrl.sv
// tb_tm_qm_ctrl -- directed testbench for tm_qm_ctrl with behavioural
// models of the six queue-manager RAMs (one-cycle read latency).

module tb_tm_qm_ctrl;
   import tm_qm_pkg::*;

   localparam int QID = 8;
   localparam int QEN = 8;

   logic             clk;
   logic             rstn;
   logic             enq_valid, enq_ready, enq_done, enq_drop;
   logic [QID-1:0]   enq_qid;
   logic [QEN-1:0]   enq_ptr;
   sch_pkt_desc_type enq_desc;
   logic             deq_valid, deq_ready, deq_done, deq_empty;
   logic [QID-1:0]   deq_qid;
   logic [QEN-1:0]   deq_ptr;
   sch_pkt_desc_type deq_desc;
   logic             head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr;
   logic [QID-1:0]   head_waddr, head_raddr, tail_waddr, tail_raddr;
   logic [QID-1:0]   depth_waddr, depth_raddr, depth1_waddr, depth1_raddr;
   logic [QEN-1:0]   head_wdata, head_rdata, tail_wdata, tail_rdata;
   logic [QEN-1:0]   depth_wdata, depth_rdata, depth1_wdata, depth1_rdata;
   logic [QEN-1:0]   ll_waddr, ll_wdata, ll_raddr, ll_rdata;
   logic [QEN-1:0]   pkt_desc_waddr, pkt_desc_raddr;
   sch_pkt_desc_type pkt_desc_wdata, pkt_desc_rdata;

   logic [QEN-1:0]   head_mem   [256];
   logic [QEN-1:0]   tail_mem   [256];
   logic [QEN-1:0]   depth_mem  [256];
   logic [QEN-1:0]   depth1_mem [256];
   logic [QEN-1:0]   ll_mem     [256];
   sch_pkt_desc_type desc_mem   [256];

   int check_count = 0;
   int fail_count  = 0;
   int total_writes = 0;
   int ll_writes    = 0;

   tm_qm_ctrl #(.QUEUE_ID_NBITS(QID), .QUEUE_ENTRIES_NBITS(QEN)) dut (
      .clk(clk), .rstn(rstn),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_qid(enq_qid),
      .enq_ptr(enq_ptr), .enq_desc(enq_desc), .enq_done(enq_done), .enq_drop(enq_drop),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_qid(deq_qid),
      .deq_done(deq_done), .deq_empty(deq_empty), .deq_ptr(deq_ptr), .deq_desc(deq_desc),
      .head_wr(head_wr), .head_waddr(head_waddr), .head_wdata(head_wdata),
      .head_raddr(head_raddr), .head_rdata(head_rdata),
      .tail_wr(tail_wr), .tail_waddr(tail_waddr), .tail_wdata(tail_wdata),
      .tail_raddr(tail_raddr), .tail_rdata(tail_rdata),
      .depth_wr(depth_wr), .depth_waddr(depth_waddr), .depth_wdata(depth_wdata),
      .depth_raddr(depth_raddr), .depth_rdata(depth_rdata),
      .depth1_wr(depth1_wr), .depth1_waddr(depth1_waddr), .depth1_wdata(depth1_wdata),
      .depth1_raddr(depth1_raddr), .depth1_rdata(depth1_rdata),
      .ll_wr(ll_wr), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
      .ll_raddr(ll_raddr), .ll_rdata(ll_rdata),
      .pkt_desc_wr(pkt_desc_wr), .pkt_desc_waddr(pkt_desc_waddr),
      .pkt_desc_wdata(pkt_desc_wdata), .pkt_desc_raddr(pkt_desc_raddr),
      .pkt_desc_rdata(pkt_desc_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: synchronous read, write visible to the next cycle's read.
   always @(posedge clk) begin
      if (head_wr)     head_mem[head_waddr]     <= head_wdata;
      if (tail_wr)     tail_mem[tail_waddr]     <= tail_wdata;
      if (depth_wr)    depth_mem[depth_waddr]   <= depth_wdata;
      if (depth1_wr)   depth1_mem[depth1_waddr] <= depth1_wdata;
      if (ll_wr)       ll_mem[ll_waddr]         <= ll_wdata;
      if (pkt_desc_wr) desc_mem[pkt_desc_waddr] <= pkt_desc_wdata;
      head_rdata     <= head_mem[head_raddr];
      tail_rdata     <= tail_mem[tail_raddr];
      depth_rdata    <= depth_mem[depth_raddr];
      depth1_rdata   <= depth1_mem[depth1_raddr];
      ll_rdata       <= ll_mem[ll_raddr];
      pkt_desc_rdata <= desc_mem[pkt_desc_raddr];
      total_writes <= total_writes + int'(head_wr) + int'(tail_wr) + int'(depth_wr)
                      + int'(depth1_wr) + int'(ll_wr) + int'(pkt_desc_wr);
      ll_writes    <= ll_writes + int'(ll_wr);
   end

   // Descriptor derived from the buffer pointer so every buffer has a distinct one.
   function automatic sch_pkt_desc_type mk_desc(input logic [QEN-1:0] p);
      sch_pkt_desc_type d;
      d.pkt_len  = {p, ~p};
      d.src_port = p ^ 8'h5A;
      return d;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      check_count++;
      if (got !== want) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // One enqueue from IDLE; called and returns on a falling edge.
   task automatic applyEnq(input logic [QID-1:0] q, input logic [QEN-1:0] p, input logic exp_drop);
      int w0;
      enq_valid = 1'b1;
      enq_qid   = q;
      enq_ptr   = p;
      enq_desc  = mk_desc(p);
      #1;
      checkOutput("enq_ready", 64'(enq_ready), 64'(1));
      checkOutput("deq_ready_quiet", 64'(deq_ready), 64'(0));
      w0 = total_writes;
      @(negedge clk);
      enq_valid = 1'b0;
      checkOutput("enq_done", 64'(enq_done), 64'(1));
      checkOutput("enq_drop", 64'(enq_drop), 64'(exp_drop));
      @(negedge clk);
      checkOutput("enq_done_pulse", 64'(enq_done), 64'(0));
      if (exp_drop) begin
         checkOutput("drop_no_writes", 64'(total_writes), 64'(w0));
         checkOutput("enq_drop_held", 64'(enq_drop), 64'(1));
      end
   endtask

   // One dequeue from IDLE; called and returns on a falling edge.
   task automatic applyDeq(input logic [QID-1:0] q, input logic exp_empty, input logic [QEN-1:0] exp_ptr);
      int w0;
      deq_valid = 1'b1;
      deq_qid   = q;
      #1;
      checkOutput("deq_ready", 64'(deq_ready), 64'(1));
      checkOutput("enq_ready_quiet", 64'(enq_ready), 64'(0));
      w0 = total_writes;
      @(negedge clk);
      deq_valid = 1'b0;
      checkOutput("deq_done_rd", 64'(deq_done), 64'(exp_empty));
      if (exp_empty) begin
         checkOutput("deq_empty", 64'(deq_empty), 64'(1));
         @(negedge clk);
         checkOutput("deq_done_pulse", 64'(deq_done), 64'(0));
         checkOutput("empty_no_writes", 64'(total_writes), 64'(w0));
      end else begin
         @(negedge clk);
         checkOutput("deq_done_ll", 64'(deq_done), 64'(1));
         checkOutput("deq_empty_clr", 64'(deq_empty), 64'(0));
         checkOutput("deq_ptr", 64'(deq_ptr), 64'(exp_ptr));
         checkOutput("deq_desc", 64'(deq_desc), 64'(mk_desc(exp_ptr)));
         @(negedge clk);
         checkOutput("deq_done_pulse", 64'(deq_done), 64'(0));
         checkOutput("deq_ptr_held", 64'(deq_ptr), 64'(exp_ptr));
      end
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 256; i++) begin
         head_mem[i]   = '0;
         tail_mem[i]   = '0;
         depth_mem[i]  = '0;
         depth1_mem[i] = '0;
         ll_mem[i]     = '0;
         desc_mem[i]   = '0;
      end
      depth_mem[7] = 8'hFF;
      rstn      = 1'b0;
      enq_valid = 1'b0;
      deq_valid = 1'b0;
      enq_qid   = '0;
      enq_ptr   = '0;
      enq_desc  = '0;
      deq_qid   = '0;

      // Reset state, including a request held during reset.
      #1;
      enq_valid = 1'b1;
      #1;
      checkOutput("rst_enq_ready", 64'(enq_ready), 64'(0));
      checkOutput("rst_tail_raddr", 64'(tail_raddr), 64'(0));
      checkOutput("rst_deq_done", 64'(deq_done), 64'(0));
      checkOutput("rst_deq_ptr", 64'(deq_ptr), 64'(0));
      checkOutput("rst_enq_drop", 64'(enq_drop), 64'(0));
      enq_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // First enqueue on an empty queue.
      applyEnq(8'd3, 8'h10, 1'b0);
      checkOutput("head3", 64'(head_mem[3]), 64'h10);
      checkOutput("tail3", 64'(tail_mem[3]), 64'h10);
      checkOutput("depth3_1", 64'(depth_mem[3]), 64'd1);
      checkOutput("depth1_3_1", 64'(depth1_mem[3]), 64'd1);
      checkOutput("no_ll_wr", 64'(ll_writes), 64'd0);

      // Two more enqueues link behind the tail.
      applyEnq(8'd3, 8'h11, 1'b0);
      applyEnq(8'd3, 8'h12, 1'b0);
      checkOutput("ll_10", 64'(ll_mem[8'h10]), 64'h11);
      checkOutput("ll_11", 64'(ll_mem[8'h11]), 64'h12);
      checkOutput("tail3_12", 64'(tail_mem[3]), 64'h12);
      checkOutput("depth3_3", 64'(depth_mem[3]), 64'd3);

      // Drain in FIFO order.
      for (int i = 0; i < 3; i++) begin
         applyDeq(8'd3, 1'b0, 8'(8'h10 + i));
         checkOutput("depth3_drain", 64'(depth_mem[3]), 64'(2 - i));
         checkOutput("depth1_3_drain", 64'(depth1_mem[3]), 64'(2 - i));
      end
      checkOutput("head3_stale", 64'(head_mem[3]), 64'h12);

      // Empty queue and saturated queue.
      applyDeq(8'd5, 1'b1, 8'h00);
      applyEnq(8'd7, 8'h30, 1'b1);
      checkOutput("depth7_sat", 64'(depth_mem[7]), 64'hFF);

      // Reset while the dequeue is in its link-read cycle.
      applyEnq(8'd4, 8'h40, 1'b0);
      deq_valid = 1'b1;
      deq_qid   = 8'd4;
      @(negedge clk);
      deq_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("pre_rst_deq_done", 64'(deq_done), 64'(1));
      w0 = total_writes;
      rstn = 1'b0;
      #1;
      checkOutput("mid_rst_deq_done", 64'(deq_done), 64'(0));
      checkOutput("mid_rst_deq_ptr", 64'(deq_ptr), 64'(0));
      checkOutput("mid_rst_depth_wr", 64'(depth_wr), 64'(0));
      checkOutput("mid_rst_desc_raddr", 64'(pkt_desc_raddr), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      checkOutput("mid_rst_no_writes", 64'(total_writes), 64'(w0));
      checkOutput("depth4_kept", 64'(depth_mem[4]), 64'd1);
      applyDeq(8'd4, 1'b0, 8'h40);

      // Both requests held on the same queue: grants alternate, enqueue first.
      enq_qid   = 8'd2;
      deq_qid   = 8'd2;
      enq_valid = 1'b1;
      deq_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         enq_ptr  = 8'(8'h20 + i / 2);
         enq_desc = mk_desc(enq_ptr);
         #1;
         checkOutput("alt_enq_ready", 64'(enq_ready), 64'((i % 2) == 0));
         checkOutput("alt_deq_ready", 64'(deq_ready), 64'((i % 2) == 1));
         @(negedge clk);
         if ((i % 2) == 0) begin
            checkOutput("alt_enq_done", 64'(enq_done), 64'(1));
            @(negedge clk);
         end else begin
            @(negedge clk);
            checkOutput("alt_deq_done", 64'(deq_done), 64'(1));
            checkOutput("alt_deq_ptr", 64'(deq_ptr), 64'(8'h20 + i / 2));
            @(negedge clk);
         end
      end
      enq_valid = 1'b0;
      deq_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
